gerenciador_ativos: RTL and testbench

Parametrised open-set manager for the path-search datapath: holds up to NUM_NA active nodes with their predecessor, accumulated distance and evaluation criterion (distance + neighbour cost). It inserts or relaxes entries, removes them by address, and repeatedly scans the table to present the minimum-criterion node. The expansion controller consumes that node through a valid/retire handshake. It generalises the earlier active-node evaluator with configurable depth, saturating criterion arithmetic, occupancy and overflow reporting, and a deterministic tie-break.

---
 rtl/gerenciador_ativos.sv | 244 ++++++++++++++++++++++++
 tb/tb_gerenciador_ativos.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gerenciador_ativos.sv
// gerenciador_ativos: open-set table for the path search; holds active nodes and presents the minimum-criterion one.
// Latency: a command accepted at edge N gives valid menor_* from edge N+NUM_NA (one slot scanned per cycle).
// Backpressure: pronto_out is low while scanning; commands seen with pronto_out low are ignored, never queued.
//
// Ports:
//   clk, rst                  single rising-edge clock, synchronous active-high reset
//   atualizar_in              insert a node or relax its distance (endereco/anterior/distancia/menor_vizinho)
//   desativar_in              remove the node at endereco_in
//   retirar_in                consume the presented minimum (only acts while menor_valido_out=1)
//   pronto_out                commands are accepted this cycle
//   menor_valido_out, menor_* minimum-criterion entry; menor_* hold their last value while not valid
//   ocupacao_out, vazio_out, cheio_out  occupancy of the table
//   estouro_out               one-cycle pulse after an insertion dropped because the table was full
//
// Build option: GERENCIADOR_ATIVOS_DESEMPATE_EN makes equal criteria resolve to the larger
// distancia (then lowest index); without it equal criteria resolve to the lowest slot index.
module gerenciador_ativos #(
    parameter int NUM_NA          = 8,
    parameter int ADR_WIDTH       = 5,
    parameter int DISTANCIA_WIDTH = 5,
    parameter int CUSTO_WIDTH     = 4,
    parameter int CRITERIO_WIDTH  = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        atualizar_in,
    input  logic                        desativar_in,
    input  logic                        retirar_in,
    input  logic [ADR_WIDTH-1:0]        endereco_in,
    input  logic [ADR_WIDTH-1:0]        anterior_in,
    input  logic [DISTANCIA_WIDTH-1:0]  distancia_in,
    input  logic [CUSTO_WIDTH-1:0]      menor_vizinho_in,
    output logic                        pronto_out,
    output logic                        menor_valido_out,
    output logic [ADR_WIDTH-1:0]        menor_endereco_out,
    output logic [ADR_WIDTH-1:0]        menor_anterior_out,
    output logic [DISTANCIA_WIDTH-1:0]  menor_distancia_out,
    output logic [CRITERIO_WIDTH-1:0]   menor_criterio_out,
    output logic [$clog2(NUM_NA+1)-1:0] ocupacao_out,
    output logic                        vazio_out,
    output logic                        cheio_out,
    output logic                        estouro_out
);
    localparam int IDX_W  = $clog2(NUM_NA);
    localparam int OCC_W  = $clog2(NUM_NA + 1);
    localparam int SOMA_W = ((DISTANCIA_WIDTH > CUSTO_WIDTH) ? DISTANCIA_WIDTH : CUSTO_WIDTH) + 1;
    localparam int EXT_W  = (SOMA_W > CRITERIO_WIDTH) ? SOMA_W : CRITERIO_WIDTH;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        VARRER = 2'd1,
        VALIDO = 2'd2
    } estado_t;

    estado_t estado, estado_prox;

    // Table storage
    logic                       tab_vld  [NUM_NA];
    logic [ADR_WIDTH-1:0]       tab_end  [NUM_NA];
    logic [ADR_WIDTH-1:0]       tab_ant  [NUM_NA];
    logic [DISTANCIA_WIDTH-1:0] tab_dist [NUM_NA];
    logic [CRITERIO_WIDTH-1:0]  tab_crit [NUM_NA];

    // Scan state: best candidate seen so far in the current pass
    logic [IDX_W-1:0]           scan_idx;
    logic                       best_vld;
    logic [IDX_W-1:0]           best_idx;
    logic [CRITERIO_WIDTH-1:0]  best_crit;
`ifdef GERENCIADOR_ATIVOS_DESEMPATE_EN
    logic [DISTANCIA_WIDTH-1:0] best_dist;
`endif
    logic [IDX_W-1:0]           sel_idx;   // slot that supplied the presented minimum

    logic                       cmd_ret, cmd_des, cmd_atu, cmd_any;
    logic                       hit, livre;
    logic [IDX_W-1:0]           hit_idx, livre_idx;
    logic [EXT_W-1:0]           soma, teto;
    logic [CRITERIO_WIDTH-1:0]  criterio_novo;
    logic [OCC_W-1:0]           ocupacao;
    logic                       cand_melhor, prox_best_vld, scan_fim;
    logic [IDX_W-1:0]           prox_best_idx;

    assign pronto_out       = (estado != VARRER);
    assign menor_valido_out = (estado == VALIDO);

    // Single command per cycle: retirar outranks desativar, which outranks atualizar
    assign cmd_ret = pronto_out & retirar_in;
    assign cmd_des = pronto_out & desativar_in & ~retirar_in;
    assign cmd_atu = pronto_out & atualizar_in & ~retirar_in & ~desativar_in;
    assign cmd_any = cmd_ret | cmd_des | cmd_atu;

    // Criterion computed wide enough to never wrap, then clamped to all-ones
    always_comb begin
        soma          = EXT_W'(distancia_in) + EXT_W'(menor_vizinho_in);
        teto          = EXT_W'({CRITERIO_WIDTH{1'b1}});
        criterio_novo = (soma > teto) ? teto[CRITERIO_WIDTH-1:0] : soma[CRITERIO_WIDTH-1:0];
    end

    // Address match and lowest free slot; descending loop leaves the lowest index
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        livre     = 1'b0;
        livre_idx = '0;
        for (int i = NUM_NA - 1; i >= 0; i--) begin
            if (tab_vld[i] && (tab_end[i] == endereco_in)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!tab_vld[i]) begin
                livre     = 1'b1;
                livre_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        ocupacao = '0;
        for (int i = 0; i < NUM_NA; i++) begin
            if (tab_vld[i]) begin
                ocupacao = ocupacao + OCC_W'(1);
            end
        end
    end

    assign ocupacao_out = ocupacao;
    assign vazio_out    = (ocupacao == '0);
    assign cheio_out    = (ocupacao == OCC_W'(NUM_NA));

    // Strict less-than keeps the earlier slot on ties unless the distancia tie-break applies
    always_comb begin
        cand_melhor = 1'b0;
        if (tab_vld[scan_idx]) begin
            if (!best_vld) begin
                cand_melhor = 1'b1;
            end else if (tab_crit[scan_idx] < best_crit) begin
                cand_melhor = 1'b1;
`ifdef GERENCIADOR_ATIVOS_DESEMPATE_EN
            end else if ((tab_crit[scan_idx] == best_crit) && (tab_dist[scan_idx] > best_dist)) begin
                cand_melhor = 1'b1;
`endif
            end
        end
        prox_best_vld = best_vld | cand_melhor;
        prox_best_idx = cand_melhor ? scan_idx : best_idx;
        scan_fim      = (scan_idx == IDX_W'(NUM_NA - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            OCIOSO, VALIDO: begin
                if (cmd_any) begin
                    estado_prox = VARRER;
                end
            end
            VARRER: begin
                if (scan_fim) begin
                    estado_prox = prox_best_vld ? VALIDO : OCIOSO;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_NA; i++) begin
                tab_vld[i] <= 1'b0;
            end
            estouro_out         <= 1'b0;
            scan_idx            <= '0;
            best_vld            <= 1'b0;
            best_idx            <= '0;
            best_crit           <= '0;
`ifdef GERENCIADOR_ATIVOS_DESEMPATE_EN
            best_dist           <= '0;
`endif
            sel_idx             <= '0;
            menor_endereco_out  <= '0;
            menor_anterior_out  <= '0;
            menor_distancia_out <= '0;
            menor_criterio_out  <= '0;
        end else begin
            estouro_out <= 1'b0;

            if (cmd_ret) begin
                if (menor_valido_out) begin
                    tab_vld[sel_idx] <= 1'b0;
                end
            end else if (cmd_des) begin
                if (hit) begin
                    tab_vld[hit_idx] <= 1'b0;
                end
            end else if (cmd_atu) begin
                if (hit) begin
                    if (distancia_in < tab_dist[hit_idx]) begin
                        tab_ant[hit_idx]  <= anterior_in;
                        tab_dist[hit_idx] <= distancia_in;
                        tab_crit[hit_idx] <= criterio_novo;
                    end
                end else if (livre) begin
                    tab_vld[livre_idx]  <= 1'b1;
                    tab_end[livre_idx]  <= endereco_in;
                    tab_ant[livre_idx]  <= anterior_in;
                    tab_dist[livre_idx] <= distancia_in;
                    tab_crit[livre_idx] <= criterio_novo;
                end else begin
                    estouro_out <= 1'b1;
                end
            end

            if (cmd_any) begin
                scan_idx <= '0;
                best_vld <= 1'b0;
            end else if (estado == VARRER) begin
                scan_idx  <= scan_fim ? '0 : scan_idx + IDX_W'(1);
                best_vld  <= prox_best_vld;
                best_idx  <= prox_best_idx;
                best_crit <= tab_crit[prox_best_idx];
`ifdef GERENCIADOR_ATIVOS_DESEMPATE_EN
                best_dist <= tab_dist[prox_best_idx];
`endif
                // Table cannot change mid-scan, so the winner's fields are read directly
                if (scan_fim && prox_best_vld) begin
                    sel_idx             <= prox_best_idx;
                    menor_endereco_out  <= tab_end[prox_best_idx];
                    menor_anterior_out  <= tab_ant[prox_best_idx];
                    menor_distancia_out <= tab_dist[prox_best_idx];
                    menor_criterio_out  <= tab_crit[prox_best_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_gerenciador_ativos.sv
// Bench for gerenciador_ativos: directed scenarios with literal expectations plus randomized
// commands, all checked every cycle against a behavioural model of the open-set table.
module tb_gerenciador_ativos;
    localparam int NUM_NA = 8;
    localparam int AW     = 5;
    localparam int DW     = 5;
    localparam int KW     = 4;
    localparam int CW     = 5;
    localparam int OW     = $clog2(NUM_NA + 1);
    localparam int CMAX   = (1 << CW) - 1;
`ifdef GERENCIADOR_ATIVOS_DESEMPATE_EN
    localparam bit DESEMPATE = 1'b1;
`else
    localparam bit DESEMPATE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          atualizar = 1'b0, desativar = 1'b0, retirar = 1'b0;
    logic [AW-1:0] endereco = '0, anterior = '0;
    logic [DW-1:0] distancia = '0;
    logic [KW-1:0] menor_vizinho = '0;
    logic          pronto, valido, vazio, cheio, estouro;
    logic [AW-1:0] m_end_o, m_ant_o;
    logic [DW-1:0] m_dist_o;
    logic [CW-1:0] m_crit_o;
    logic [OW-1:0] ocupacao;

    always #5 clk = ~clk;

    gerenciador_ativos #(
        .NUM_NA(NUM_NA), .ADR_WIDTH(AW), .DISTANCIA_WIDTH(DW),
        .CUSTO_WIDTH(KW), .CRITERIO_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .atualizar_in(atualizar), .desativar_in(desativar), .retirar_in(retirar),
        .endereco_in(endereco), .anterior_in(anterior), .distancia_in(distancia),
        .menor_vizinho_in(menor_vizinho),
        .pronto_out(pronto), .menor_valido_out(valido),
        .menor_endereco_out(m_end_o), .menor_anterior_out(m_ant_o),
        .menor_distancia_out(m_dist_o), .menor_criterio_out(m_crit_o),
        .ocupacao_out(ocupacao), .vazio_out(vazio), .cheio_out(cheio), .estouro_out(estouro)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Behavioural model: table contents, remaining scan cycles, presented minimum
    bit m_vld  [NUM_NA];
    int m_end  [NUM_NA];
    int m_ant  [NUM_NA];
    int m_dist [NUM_NA];
    int m_crit [NUM_NA];
    int m_busy = 0;
    int m_sel = 0;
    bit m_valid = 1'b0;
    bit m_estouro = 1'b0;
    int m_me = 0, m_ma = 0, m_md = 0, m_mc = 0;

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nome, got, exp, $time);
        end
    endtask

    function automatic int crit_of(input int d, input int c);
        return (d + c > CMAX) ? CMAX : d + c;
    endfunction

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < NUM_NA; i++) n += m_vld[i] ? 1 : 0;
        return n;
    endfunction

    // End of scan: lowest criterion wins; among equals, larger distance (option) then lowest slot
    task automatic model_fim();
        int minc = CMAX + 1;
        int best = -1;
        for (int i = 0; i < NUM_NA; i++)
            if (m_vld[i] && m_crit[i] < minc) minc = m_crit[i];
        for (int i = 0; i < NUM_NA; i++)
            if (m_vld[i] && m_crit[i] == minc)
                if (best < 0 || (DESEMPATE && m_dist[i] > m_dist[best])) best = i;
        if (best >= 0) begin
            m_valid = 1'b1;
            m_sel   = best;
            m_me    = m_end[best];
            m_ma    = m_ant[best];
            m_md    = m_dist[best];
            m_mc    = m_crit[best];
        end
    endtask

    task automatic model_step();
        int hit, livre;
        if (rst) begin
            for (int i = 0; i < NUM_NA; i++) m_vld[i] = 1'b0;
            m_busy = 0; m_valid = 1'b0; m_estouro = 1'b0;
            m_me = 0; m_ma = 0; m_md = 0; m_mc = 0;
            return;
        end
        m_estouro = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) model_fim();
        end else if (retirar || desativar || atualizar) begin
            if (retirar) begin
                if (m_valid) m_vld[m_sel] = 1'b0;
            end else if (desativar) begin
                for (int i = 0; i < NUM_NA; i++)
                    if (m_vld[i] && m_end[i] == int'(endereco)) m_vld[i] = 1'b0;
            end else begin
                hit = -1;
                for (int i = 0; i < NUM_NA; i++)
                    if (hit < 0 && m_vld[i] && m_end[i] == int'(endereco)) hit = i;
                if (hit >= 0) begin
                    if (int'(distancia) < m_dist[hit]) begin
                        m_ant[hit]  = int'(anterior);
                        m_dist[hit] = int'(distancia);
                        m_crit[hit] = crit_of(int'(distancia), int'(menor_vizinho));
                    end
                end else begin
                    livre = -1;
                    for (int i = 0; i < NUM_NA; i++)
                        if (livre < 0 && !m_vld[i]) livre = i;
                    if (livre >= 0) begin
                        m_vld[livre]  = 1'b1;
                        m_end[livre]  = int'(endereco);
                        m_ant[livre]  = int'(anterior);
                        m_dist[livre] = int'(distancia);
                        m_crit[livre] = crit_of(int'(distancia), int'(menor_vizinho));
                    end else begin
                        m_estouro = 1'b1;
                    end
                end
            end
            m_valid = 1'b0;
            m_busy  = NUM_NA;
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_on) begin
            chk("pronto", pronto, m_busy == 0);
            chk("valido", valido, m_valid);
            chk("ocupacao", ocupacao, m_count());
            chk("vazio", vazio, m_count() == 0);
            chk("cheio", cheio, m_count() == NUM_NA);
            chk("estouro", estouro, m_estouro);
            chk("menor_endereco", m_end_o, m_me);
            chk("menor_anterior", m_ant_o, m_ma);
            chk("menor_distancia", m_dist_o, m_md);
            chk("menor_criterio", m_crit_o, m_mc);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cmd(input bit a, input bit d, input bit r,
                       input int e, input int an, input int di, input int cu);
        atualizar = a; desativar = d; retirar = r;
        endereco = AW'(e); anterior = AW'(an); distancia = DW'(di); menor_vizinho = KW'(cu);
        tick();
        atualizar = 1'b0; desativar = 1'b0; retirar = 1'b0;
    endtask

    task automatic atu(input int e, input int an, input int di, input int cu);
        cmd(1'b1, 1'b0, 1'b0, e, an, di, cu);
    endtask

    task automatic settle();
        repeat (NUM_NA) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk_on = 1'b1;
        chk("reset_pronto", pronto, 1);
        chk("reset_vazio", vazio, 1);
        chk("reset_ocupacao", ocupacao, 0);
        chk("reset_valido", valido, 0);
        chk("reset_criterio", m_crit_o, 0);

        // First insertion
        atu(2, 1, 20, 5);
        chk("t1_pronto_busy", pronto, 0);
        settle();
        chk("t1_valido", valido, 1);
        chk("t1_endereco", m_end_o, 2);
        chk("t1_distancia", m_dist_o, 20);
        chk("t1_criterio", m_crit_o, 25);
        chk("t1_ocupacao", ocupacao, 1);
        chk("t1_vazio", vazio, 0);

        // Relaxation
        atu(3, 0, 10, 5); settle();
        atu(4, 0, 15, 5); settle();
        chk("t2_endereco", m_end_o, 3);
        chk("t2_criterio", m_crit_o, 15);
        atu(4, 7, 5, 5); settle();
        chk("t2_relax_endereco", m_end_o, 4);
        chk("t2_relax_anterior", m_ant_o, 7);
        chk("t2_relax_criterio", m_crit_o, 10);
        atu(4, 9, 12, 5); settle();
        chk("t2_norelax_anterior", m_ant_o, 7);
        chk("t2_norelax_criterio", m_crit_o, 10);

        // Removal by address
        cmd(1'b0, 1'b1, 1'b0, 4, 0, 0, 0); settle();
        chk("t3_endereco", m_end_o, 3);
        chk("t3_ocupacao", ocupacao, 2);
        cmd(1'b0, 1'b1, 1'b0, 9, 0, 0, 0); settle();
        chk("t3_absent_ocupacao", ocupacao, 2);
        chk("t3_absent_endereco", m_end_o, 3);

        // Overflow
        do_reset();
        for (int i = 0; i < NUM_NA; i++) begin
            atu(10 + i, 1, 3 + i, 1);
            settle();
        end
        chk("t4_cheio_pre", cheio, 1);
        atu(18, 2, 0, 0);
        chk("t4_estouro_pulse", estouro, 1);
        tick();
        chk("t4_estouro_end", estouro, 0);
        repeat (NUM_NA - 1) tick();
        chk("t4_cheio", cheio, 1);
        chk("t4_ocupacao", ocupacao, 8);
        chk("t4_endereco", m_end_o, 10);
        chk("t4_criterio", m_crit_o, 4);

        // Tie-break
        do_reset();
        atu(5, 0, 10, 6); settle();
        atu(6, 0, 14, 2); settle();
        chk("t5_tie_endereco", m_end_o, DESEMPATE ? 6 : 5);
        chk("t5_tie_criterio", m_crit_o, 16);

        // Saturation and drain
        atu(7, 3, 20, 15); settle();
        cmd(1'b0, 1'b0, 1'b1, 0, 0, 0, 0); settle();
        chk("t6_second_endereco", m_end_o, DESEMPATE ? 5 : 6);
        cmd(1'b0, 1'b0, 1'b1, 0, 0, 0, 0); settle();
        chk("t6_sat_endereco", m_end_o, 7);
        chk("t6_sat_criterio", m_crit_o, 31);
        cmd(1'b0, 1'b0, 1'b1, 0, 0, 0, 0); settle();
        chk("t6_drain_vazio", vazio, 1);
        chk("t6_drain_valido", valido, 0);

        // Reset mid-scan
        atu(20, 0, 3, 3);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_pronto", pronto, 1);
        chk("t6_rst_ocupacao", ocupacao, 0);

        // Randomized commands, many of them arriving while the scan is busy
        for (int k = 0; k < 3000; k++) begin
            int p;
            p = $urandom_range(0, 99);
            rst           = ($urandom_range(0, 399) == 0);
            atualizar     = (p < 50);
            desativar     = (p >= 40 && p < 60);
            retirar       = (p >= 55 && p < 80);
            endereco      = AW'($urandom_range(0, 11));
            anterior      = AW'($urandom_range(0, 31));
            distancia     = DW'($urandom_range(0, 31));
            menor_vizinho = KW'($urandom_range(0, 15));
            tick();
        end
        rst = 1'b0; atualizar = 1'b0; desativar = 1'b0; retirar = 1'b0;
        settle();

        // Drain whatever is left; the model checks the order each cycle
        for (int k = 0; k < NUM_NA + 2; k++) begin
            cmd(1'b0, 1'b0, 1'b1, 0, 0, 0, 0);
            settle();
        end
        chk("final_vazio", vazio, 1);
        chk("final_valido", valido, 0);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
